// File: rtl/regfile_sb.sv
// Clocked register file: one write port, two registered read ports with write-first bypass,
// and a per-register pending bit that decode uses to stall on RAW hazards.
module regfile_sb #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 32,
  parameter int ZERO_REG = 0,
  localparam int AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rf,
  input  logic [AW-1:0]    rs1,
  input  logic [AW-1:0]    rs2,
  output logic [WIDTH-1:0] rd1,
  output logic [WIDTH-1:0] rd2,
  output logic             rd1_busy,
  output logic             rd2_busy,
  input  logic             wf,
  input  logic [AW-1:0]    ws,
  input  logic [WIDTH-1:0] wd,
  input  logic             iss,
  input  logic [AW-1:0]    ia
);

  localparam logic [AW:0] DEPTH_W = DEPTH[AW:0];

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [DEPTH-1:0] pend_r;
  logic [DEPTH-1:0] pend_nxt_s;
  logic [WIDTH-1:0] rd1_r, rd2_r;
  logic [WIDTH-1:0] val1_s, val2_s;
  logic             wr_ok_s, iss_ok_s;
  logic             busy1_s, busy2_s;

  // Addresses at or beyond DEPTH exist only when DEPTH is not a power of two.
  function automatic logic in_range(input logic [AW-1:0] a);
    return ({1'b0, a} < DEPTH_W);
  endfunction

  function automatic logic is_zero(input logic [AW-1:0] a);
    return (ZERO_REG != 0) && (a == {AW{1'b0}});
  endfunction

  function automatic logic [WIDTH-1:0] read_val(input logic [AW-1:0] a);
    return (!in_range(a) || is_zero(a)) ? {WIDTH{1'b0}} :
           (wr_ok_s && (ws == a))      ? wd :
                                         mem_r[a];
  endfunction

  // A pending register is not reported busy while its writeback is on the bus this cycle.
  function automatic logic busy_of(input logic [AW-1:0] a);
    return in_range(a) && !is_zero(a) && pend_r[a] && !(wf && (ws == a));
  endfunction

  // Write qualification, bypassed read values and busy flags.
  always_comb begin
    wr_ok_s  = wf && in_range(ws) && !is_zero(ws);
    iss_ok_s = iss && in_range(ia) && !is_zero(ia);
    val1_s   = read_val(rs1);
    val2_s   = read_val(rs2);
    busy1_s  = busy_of(rs1);
    busy2_s  = busy_of(rs2);
  end

  // Next pending vector: an issue to the same register as a writeback wins over the clear.
  always_comb begin
    pend_nxt_s = {DEPTH{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      pend_nxt_s[i] = (iss_ok_s && (ia == AW'(i))) ||
                      (pend_r[i] && !(wr_ok_s && (ws == AW'(i))));
    end
  end

  // Register array storage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
    end else if (wr_ok_s) begin
      mem_r[ws] <= wd;
    end
  end

  // Scoreboard pending bits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_r <= {DEPTH{1'b0}};
    end else begin
      pend_r <= pend_nxt_s;
    end
  end

  // Registered read ports; they hold while rf is low.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd1_r <= {WIDTH{1'b0}};
      rd2_r <= {WIDTH{1'b0}};
    end else if (rf) begin
      rd1_r <= val1_s;
      rd2_r <= val2_s;
    end
  end

  assign rd1      = rd1_r;
  assign rd2      = rd2_r;
  assign rd1_busy = busy1_s;
  assign rd2_busy = busy2_s;

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench: three register-file configurations driven by directed and random
// stimulus, compared every cycle against an array-based reference model.
module tb_regfile_sb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        rf_v [3];
  logic        wf_v [3];
  logic        iss_v [3];
  logic [4:0]  rs1_v [3];
  logic [4:0]  rs2_v [3];
  logic [4:0]  ws_v [3];
  logic [4:0]  ia_v [3];
  logic [31:0] wd_v [3];

  logic [31:0] a_rd1, a_rd2;
  logic [15:0] b_rd1, b_rd2;
  logic [7:0]  c_rd1, c_rd2;
  logic        a_b1, a_b2, b_b1, b_b2, c_b1, c_b2;

  int n_vec;
  int n_err;

  // Instance 0: 32x32 with hardwired zero register.
  regfile_sb #(.WIDTH(32), .DEPTH(32), .ZERO_REG(1)) u_a (
    .clk(clk), .reset(rst), .rf(rf_v[0]), .rs1(rs1_v[0]), .rs2(rs2_v[0]),
    .rd1(a_rd1), .rd2(a_rd2), .rd1_busy(a_b1), .rd2_busy(a_b2),
    .wf(wf_v[0]), .ws(ws_v[0]), .wd(wd_v[0]), .iss(iss_v[0]), .ia(ia_v[0]));

  // Instance 1: 16-bit x 8, register 0 writable.
  regfile_sb #(.WIDTH(16), .DEPTH(8), .ZERO_REG(0)) u_b (
    .clk(clk), .reset(rst), .rf(rf_v[1]), .rs1(rs1_v[1][2:0]), .rs2(rs2_v[1][2:0]),
    .rd1(b_rd1), .rd2(b_rd2), .rd1_busy(b_b1), .rd2_busy(b_b2),
    .wf(wf_v[1]), .ws(ws_v[1][2:0]), .wd(wd_v[1][15:0]), .iss(iss_v[1]), .ia(ia_v[1][2:0]));

  // Instance 2: 8-bit x 5, so addresses 5..7 are out of range.
  regfile_sb #(.WIDTH(8), .DEPTH(5), .ZERO_REG(0)) u_c (
    .clk(clk), .reset(rst), .rf(rf_v[2]), .rs1(rs1_v[2][2:0]), .rs2(rs2_v[2][2:0]),
    .rd1(c_rd1), .rd2(c_rd2), .rd1_busy(c_b1), .rd2_busy(c_b2),
    .wf(wf_v[2]), .ws(ws_v[2][2:0]), .wd(wd_v[2][7:0]), .iss(iss_v[2]), .ia(ia_v[2][2:0]));

  // Reference model state.
  logic [31:0] mem_m [3][32];
  bit          pend_m [3][32];
  logic [31:0] rd1_m [3];
  logic [31:0] rd2_m [3];

  function automatic int dep(int k);
    case (k)
      0:       return 32;
      1:       return 8;
      default: return 5;
    endcase
  endfunction

  function automatic bit zr(int k);
    return (k == 0);
  endfunction

  function automatic logic [31:0] msk(int k);
    case (k)
      0:       return 32'hFFFF_FFFF;
      1:       return 32'h0000_FFFF;
      default: return 32'h0000_00FF;
    endcase
  endfunction

  function automatic logic [31:0] mval(int k, int a);
    if (a >= dep(k)) return 32'h0;
    if (zr(k) && a == 0) return 32'h0;
    if (wf_v[k] && int'(ws_v[k]) == a) return wd_v[k] & msk(k);
    return mem_m[k][a];
  endfunction

  function automatic logic [31:0] mbusy(int k, int a);
    if (a >= dep(k)) return 32'h0;
    if (wf_v[k] && int'(ws_v[k]) == a) return 32'h0;
    return {31'h0, pend_m[k][a]};
  endfunction

  function automatic logic [31:0] got_rd(int k, int p);
    case (k)
      0:       return (p == 1) ? a_rd1 : a_rd2;
      1:       return {16'h0, (p == 1) ? b_rd1 : b_rd2};
      default: return {24'h0, (p == 1) ? c_rd1 : c_rd2};
    endcase
  endfunction

  function automatic logic [31:0] got_busy(int k, int p);
    case (k)
      0:       return {31'h0, (p == 1) ? a_b1 : a_b2};
      1:       return {31'h0, (p == 1) ? b_b1 : b_b2};
      default: return {31'h0, (p == 1) ? c_b1 : c_b2};
    endcase
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < 3; k++) begin
      rd1_m[k] = 32'h0;
      rd2_m[k] = 32'h0;
      for (int i = 0; i < 32; i++) begin
        mem_m[k][i]  = 32'h0;
        pend_m[k][i] = 1'b0;
      end
    end
  endtask

  task automatic idle();
    for (int k = 0; k < 3; k++) begin
      rf_v[k] = 1'b0; wf_v[k] = 1'b0; iss_v[k] = 1'b0;
      rs1_v[k] = 5'd0; rs2_v[k] = 5'd0; ws_v[k] = 5'd0; ia_v[k] = 5'd0;
      wd_v[k] = 32'h0;
    end
  endtask

  // Check busy mid-cycle, advance the model, take the edge, then check read data.
  task automatic tick();
    #2;
    for (int k = 0; k < 3; k++) begin
      check_eq($sformatf("busy1_i%0d", k), got_busy(k, 1), mbusy(k, int'(rs1_v[k])));
      check_eq($sformatf("busy2_i%0d", k), got_busy(k, 2), mbusy(k, int'(rs2_v[k])));
    end
    if (rst) begin
      model_clear();
    end else begin
      for (int k = 0; k < 3; k++) begin
        logic [31:0] v1, v2;
        v1 = mval(k, int'(rs1_v[k]));
        v2 = mval(k, int'(rs2_v[k]));
        if (rf_v[k]) begin
          rd1_m[k] = v1;
          rd2_m[k] = v2;
        end
        if (wf_v[k] && ws_v[k] < dep(k) && !(zr(k) && ws_v[k] == 0))
          mem_m[k][ws_v[k]] = wd_v[k] & msk(k);
        if (wf_v[k] && ws_v[k] < dep(k))
          pend_m[k][ws_v[k]] = 1'b0;
        if (iss_v[k] && ia_v[k] < dep(k) && !(zr(k) && ia_v[k] == 0))
          pend_m[k][ia_v[k]] = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      check_eq($sformatf("rd1_i%0d", k), got_rd(k, 1), rd1_m[k]);
      check_eq($sformatf("rd2_i%0d", k), got_rd(k, 2), rd2_m[k]);
    end
  endtask

  function automatic logic [4:0] raddr(int k);
    if (k == 0) return ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
    return 5'($urandom_range(0, 7));
  endfunction

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b1;
    idle();
    model_clear();
    #1;
    tick();
    rst = 1'b0;

    // Write then read, then hold with rf low.
    idle(); wf_v[0] = 1'b1; ws_v[0] = 5'd3; wd_v[0] = 32'hDEAD_BEEF; tick();
    idle(); rf_v[0] = 1'b1; rs1_v[0] = 5'd3; tick();
    check_eq("t2_read", a_rd1, 32'hDEAD_BEEF);
    idle(); rs1_v[0] = 5'd9; tick();
    check_eq("t2_hold", a_rd1, 32'hDEAD_BEEF);

    // Same-cycle write bypass to both ports.
    idle(); wf_v[0] = 1'b1; ws_v[0] = 5'd7; wd_v[0] = 32'h1234_5678;
    rf_v[0] = 1'b1; rs1_v[0] = 5'd7; rs2_v[0] = 5'd7; tick();
    check_eq("t3_byp1", a_rd1, 32'h1234_5678);
    check_eq("t3_byp2", a_rd2, 32'h1234_5678);

    // Scoreboard set, hidden by writeback, cleared, and set-wins.
    idle(); iss_v[0] = 1'b1; ia_v[0] = 5'd4; tick();
    idle(); rs1_v[0] = 5'd4; #1; check_eq("t4_busy", {31'h0, a_b1}, 32'h1); tick();
    idle(); rs1_v[0] = 5'd4; wf_v[0] = 1'b1; ws_v[0] = 5'd4; wd_v[0] = 32'h55;
    #1; check_eq("t4_hide", {31'h0, a_b1}, 32'h0); tick();
    idle(); rs1_v[0] = 5'd4; #1; check_eq("t4_clr", {31'h0, a_b1}, 32'h0); tick();
    idle(); iss_v[0] = 1'b1; ia_v[0] = 5'd9; wf_v[0] = 1'b1; ws_v[0] = 5'd9; wd_v[0] = 32'h1; tick();
    idle(); rs2_v[0] = 5'd9; #1; check_eq("t4_setwin", {31'h0, a_b2}, 32'h1); tick();

    // Zero register hardwired on instance 0, writable on instance 1.
    idle(); wf_v[0] = 1'b1; ws_v[0] = 5'd0; wd_v[0] = 32'hFFFF_FFFF; iss_v[0] = 1'b1;
    wf_v[1] = 1'b1; ws_v[1] = 5'd0; wd_v[1] = 32'hFFFF_FFFF; tick();
    idle(); rf_v[0] = 1'b1; rf_v[1] = 1'b1;
    #1; check_eq("t5_zbusy", {31'h0, a_b1}, 32'h0); tick();
    check_eq("t5_zread", a_rd1, 32'h0);
    check_eq("t5_r0", {16'h0, b_rd1}, 32'h0000_FFFF);

    // Fill all of instance 1, then read with wrapped pairs.
    for (int i = 0; i < 8; i++) begin
      idle(); wf_v[1] = 1'b1; ws_v[1] = 5'(i); wd_v[1] = 32'hA5A0 + 32'(i); tick();
    end
    for (int i = 0; i < 8; i++) begin
      idle(); rf_v[1] = 1'b1; rs1_v[1] = 5'(i); rs2_v[1] = 5'((i + 7) % 8); tick();
      check_eq("t6_p1", {16'h0, b_rd1}, 32'hA5A0 + 32'(i));
      check_eq("t6_p2", {16'h0, b_rd2}, 32'hA5A0 + 32'((i + 7) % 8));
    end

    // Out-of-range addresses on instance 2; last valid register still works.
    idle(); wf_v[2] = 1'b1; ws_v[2] = 5'd6; wd_v[2] = 32'h77; iss_v[2] = 1'b1; ia_v[2] = 5'd7; tick();
    idle(); wf_v[2] = 1'b1; ws_v[2] = 5'd4; wd_v[2] = 32'h3C; tick();
    idle(); rf_v[2] = 1'b1; rs1_v[2] = 5'd6; rs2_v[2] = 5'd4;
    #1; check_eq("oor_busy", {31'h0, c_b1}, 32'h0); tick();
    check_eq("oor_read", {24'h0, c_rd1}, 32'h0);
    check_eq("last_read", {24'h0, c_rd2}, 32'h3C);

    // Reset mid-cycle with a write in flight.
    idle(); wf_v[0] = 1'b1; ws_v[0] = 5'd5; wd_v[0] = 32'hAAAA_5555; rf_v[0] = 1'b1; rs1_v[0] = 5'd3;
    #1; rst = 1'b1; model_clear(); #1;
    check_eq("t1_rd1", a_rd1, 32'h0);
    check_eq("t1_rd2", {16'h0, b_rd2}, 32'h0);
    tick();
    rst = 1'b0;
    idle(); rf_v[0] = 1'b1; rs1_v[0] = 5'd5; tick();
    check_eq("t1_r5", a_rd1, 32'h0);

    // Randomized traffic on all instances.
    for (int n = 0; n < 10000; n++) begin
      for (int k = 0; k < 3; k++) begin
        rf_v[k]  = 1'($urandom_range(0, 1));
        wf_v[k]  = 1'($urandom_range(0, 1));
        iss_v[k] = ($urandom_range(0, 3) == 0);
        rs1_v[k] = raddr(k);
        rs2_v[k] = raddr(k);
        ws_v[k]  = raddr(k);
        ia_v[k]  = raddr(k);
        wd_v[k]  = $urandom;
      end
      if ($urandom_range(0, 999) == 0) begin
        rst = 1'b1;
        model_clear();
        tick();
        rst = 1'b0;
      end else begin
        tick();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
